// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache. Hits are answered combinationally
// in IDLE; a miss refills the whole line word by word from the MMU port.
module instruction_cache #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic                  cpu_read,
    output logic [DATA_WIDTH-1:0] cpu_instr,
    output logic                  cpu_hit,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_ready
);

    localparam int OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SETS-1:0]         r_valid;
    logic [TAG_W-1:0]        r_tag  [SETS];
    logic [DATA_WIDTH-1:0]   r_data [SETS*WORDS_PER_LINE];
    logic [TAG_W-1:0]        r_refill_tag;
    logic [IDX_W-1:0]        r_refill_idx;
    logic [OFF_W-1:0]        r_count;
    logic                    r_flush_pending;

    logic [TAG_W-1:0]        w_req_tag;
    logic [IDX_W-1:0]        w_req_idx;
    logic [OFF_W-1:0]        w_req_off;
    logic                    w_line_match;
    logic                    w_hit;
    logic                    w_start;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_unused_byte_bits;

    assign w_req_tag          = cpu_address[ADDR_WIDTH-1:TAG_LSB];
    assign w_req_idx          = cpu_address[TAG_LSB-1:IDX_LSB];
    assign w_req_off          = cpu_address[IDX_LSB-1:2];
    assign w_unused_byte_bits = &cpu_address[1:0];

    assign w_line_match = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
    assign w_hit        = (r_state == S_IDLE) && cpu_read && w_line_match && !flush;
    assign w_start      = (r_state == S_IDLE) && cpu_read && !w_line_match && !flush;
    assign w_accept     = (r_state == S_REQ) && mem_ready;
    assign w_last       = (r_count == LAST_WORD);

    always_comb begin
        w_state_next = r_state;
        cpu_hit      = w_hit;
        cpu_instr    = '0;
        mem_read     = 1'b0;
        mem_address  = '0;
        if (w_hit) begin
            cpu_instr = r_data[{w_req_idx, w_req_off}];
        end
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                mem_read    = 1'b1;
                mem_address = {r_refill_tag, r_refill_idx, r_count, 2'b00};
                if (mem_ready) begin
                    w_state_next = w_last ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                w_state_next = S_REQ;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_valid         <= '0;
            r_count         <= '0;
            r_flush_pending <= 1'b0;
            r_refill_tag    <= '0;
            r_refill_idx    <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (w_start) begin
                        r_refill_tag <= w_req_tag;
                        r_refill_idx <= w_req_idx;
                        r_count      <= '0;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (mem_ready) begin
                        if (w_last) begin
                            r_count         <= '0;
                            r_flush_pending <= 1'b0;
                            // A flush seen during the refill wipes everything, new line included.
                            if (flush || r_flush_pending) begin
                                r_valid <= '0;
                            end else begin
                                r_valid[r_refill_idx] <= 1'b1;
                            end
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (flush) begin
                        r_flush_pending <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits alone guard them.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_data[{r_refill_idx, r_count}] <= mem_data;
            if (w_last) begin
                r_tag[r_refill_idx] <= r_refill_tag;
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: directed fetches push expected MMU
// addresses and hit data; a negedge monitor pops and compares.
module tb_instruction_cache;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_address = '0;
    logic        cpu_read = 1'b0;
    logic [31:0] cpu_instr;
    logic        cpu_hit;
    logic        flush = 1'b0;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [31:0] mem_data;
    logic        mem_ready;

    logic        ready_always = 1'b0;
    int          wait_cnt = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          accepts_seen = 0;
    int          hits_seen = 0;
    logic        prev_acc = 1'b0;
    int          cyc;

    instruction_cache dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_address (cpu_address),
        .cpu_read    (cpu_read),
        .cpu_instr   (cpu_instr),
        .cpu_hit     (cpu_hit),
        .flush       (flush),
        .mem_address (mem_address),
        .mem_read    (mem_read),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready)
    );

    always #5 clock = ~clock;

    // Memory model: completes each request on its third REQ cycle unless forced ready.
    always_comb mem_ready = ready_always | (mem_read && (wait_cnt == 2));
    assign mem_data = 32'hA0 + ((mem_address >> 2) & 32'h3) + (mem_address & 32'hFFFF_FF00);
    always @(posedge clock) wait_cnt <= (mem_read && !mem_ready) ? wait_cnt + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected %s", name, act, why);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_acc = 1'b0;
            end else begin
                if (prev_acc) check("gap_mem_read_low", {31'd0, mem_read}, 32'd0);
                if (mem_read && mem_ready) begin
                    if (exp_addr.size() == 0) fail_now("mem_accept", mem_address, "no request");
                    else check("mem_address", mem_address, exp_addr.pop_front());
                    accepts_seen++;
                end else if (mem_read && exp_addr.size() == 0) begin
                    fail_now("mem_read", mem_address, "no request");
                end
                prev_acc = mem_read && mem_ready;
                if (cpu_hit) begin
                    if (exp_instr.size() == 0) fail_now("cpu_hit", cpu_instr, "no hit");
                    else check("cpu_instr", cpu_instr, exp_instr.pop_front());
                    hits_seen++;
                end else if (cpu_instr !== 32'd0) begin
                    check("instr_zero_on_miss", cpu_instr, 32'd0);
                end
            end
        end
    end

    task automatic push_line(input logic [31:0] base);
        for (int w = 0; w < 4; w++) exp_addr.push_back(base + 32'(w * 4));
    endtask

    task automatic start_fetch(input logic [31:0] a);
        cpu_address = a;
        cpu_read    = 1'b1;
    endtask

    task automatic wait_hit(input string name, output int cycles);
        int h0;
        h0 = hits_seen;
        cycles = 0;
        while (hits_seen == h0 && cycles < 300) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        cpu_read = 1'b0;
        if (hits_seen == h0) fail_now({name, "_hit_timeout"}, 32'(cycles), "a hit");
        check({name, "_reads_done"}, 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic wait_req(input string name, input logic [31:0] a);
        int n;
        n = 0;
        while (!(mem_read && mem_address == a) && n < 300) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 300) fail_now({name, "_req_timeout"}, mem_address, "request seen");
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state with a request already pending.
        cpu_address = 32'h40;
        cpu_read    = 1'b1;
        step();
        step();
        check("rst_cpu_hit", {31'd0, cpu_hit}, 32'd0);
        check("rst_cpu_instr", cpu_instr, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        cpu_read = 1'b0;
        reset    = 1'b0;
        step();

        // 1: cold miss at 0x40.
        push_line(32'h40);
        exp_instr.push_back(32'hA0);
        start_fetch(32'h40);
        wait_hit("cold_40", cyc);
        check("cold_40_latency", 32'(cyc), 32'd17);
        step();

        // 2: same line, different word, same-cycle hit.
        exp_instr.push_back(32'hA2);
        start_fetch(32'h48);
        wait_hit("hit_48", cyc);
        check("hit_48_latency", 32'(cyc), 32'd1);

        // Flush in IDLE suppresses the hit and the refill that cycle.
        start_fetch(32'h40);
        flush = 1'b1;
        #1;
        check("idle_flush_no_hit", {31'd0, cpu_hit}, 32'd0);
        push_line(32'h40);
        exp_instr.push_back(32'hA0);
        step();
        flush = 1'b0;
        wait_hit("post_flush_40", cyc);
        check("post_flush_40_latency", 32'(cyc), 32'd17);
        step();

        // 3: conflict on index 4.
        push_line(32'h140);
        exp_instr.push_back(32'h1A0);
        start_fetch(32'h140);
        wait_hit("conflict_140", cyc);
        step();
        push_line(32'h40);
        exp_instr.push_back(32'hA0);
        start_fetch(32'h40);
        wait_hit("refetch_40", cyc);
        step();

        // 4: flush pulse during word 1 of the 0x80 refill.
        push_line(32'h80);
        push_line(32'h80);
        exp_instr.push_back(32'hA0);
        start_fetch(32'h80);
        wait_req("flush_80", 32'h84);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_hit("flush_80", cyc);
        step();
        push_line(32'h40);
        exp_instr.push_back(32'hA0);
        start_fetch(32'h40);
        wait_hit("flushed_40", cyc);
        step();

        // 5: reset while word 2 of the 0xC0 refill is requested.
        push_line(32'hC0);
        start_fetch(32'hC0);
        wait_req("reset_c0", 32'hC8);
        reset = 1'b1;
        #1;
        check("async_rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("async_rst_mem_address", mem_address, 32'd0);
        check("async_rst_words_left", 32'(exp_addr.size()), 32'd2);
        exp_addr.delete();
        exp_instr.delete();
        cpu_read = 1'b0;
        step();
        reset = 1'b0;
        step();
        push_line(32'h40);
        exp_instr.push_back(32'hA0);
        start_fetch(32'h40);
        wait_hit("after_rst_40", cyc);
        check("after_rst_40_latency", 32'(cyc), 32'd17);
        step();

        // 6: ready held high, address switched mid-refill.
        flush = 1'b1;
        step();
        flush = 1'b0;
        ready_always = 1'b1;
        push_line(32'h40);
        push_line(32'h200);
        exp_instr.push_back(32'h2A0);
        start_fetch(32'h40);
        begin
            int a0;
            int n;
            a0 = accepts_seen;
            n = 0;
            while (accepts_seen == a0 && n < 300) begin
                step();
                n++;
            end
            if (n >= 300) fail_now("switch_first_accept", 32'(n), "an accept");
        end
        cpu_address = 32'h200;
        wait_hit("switch_200", cyc);
        step();
        exp_instr.push_back(32'hA0);
        start_fetch(32'h40);
        wait_hit("still_40", cyc);
        check("still_40_latency", 32'(cyc), 32'd1);
        step();
        check("hits_left", 32'(exp_instr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time 0x%08h reached, expected test end", 32'd200000);
        $fatal(1, "watchdog");
    end

endmodule
